cpu: RTL and testbench

//  16-bit accumulator CPU with 10-bit word address; pairs with an external asynchronous-read memory.

---
 rtl/cpu.sv | 74 +++++++
 tb/tb_cpu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: 16-bit accumulator CPU with two-cycle fetch/execute over separate program and data spaces
module cpu (
  input  logic        clk,
  input  logic        rst_pc,
  input  logic        rst_acc,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic [9:0]  addr,
  output logic        wr,
  output logic        addr_mode,
  output logic [15:0] alu_out
);
  typedef enum logic [1:0] {FETCH, EXECUTE, HALT} state_t;
  state_t      state, state_nxt;
  logic [9:0]  pc, pc_nxt, k;
  logic [13:0] ir;
  logic [3:0]  op;
  logic [15:0] acc, acc_nxt;
  logic        c, c_nxt, jump, alu_op;
  assign op       = ir[13:10];
  assign k        = ir[9:0];
  assign data_out = acc;
  // bus decode and sequencing: driven from registered state and IR only, so the bus stays glitch-free
  always_comb begin
    addr_mode = state == EXECUTE;
    addr      = addr_mode ? k : pc;
    wr        = addr_mode && op == 4'h2;
    jump      = op == 4'hB || (op == 4'hC && acc == 16'h0) || (op == 4'hD && acc[15]);
    state_nxt = state == FETCH ? EXECUTE : (state == EXECUTE && op != 4'hF) ? FETCH : HALT;
    pc_nxt    = state == FETCH ? pc + 10'd1 : (addr_mode && jump) ? k : pc;
    alu_op    = (op >= 4'h3 && op <= 4'hA) || op == 4'hE;
  end
  // accumulator datapath; carry rides in the 17th bit of the add/sub/shift results
  always_comb begin
    {c_nxt, acc_nxt} = {c, acc};
    case (op)
      4'h1:    acc_nxt = data_in;
      4'h3:    {c_nxt, acc_nxt} = {1'b0, acc} + {1'b0, data_in};
      4'h4:    {c_nxt, acc_nxt} = {1'b0, acc} - {1'b0, data_in};
      4'h5:    acc_nxt = acc & data_in;
      4'h6:    acc_nxt = acc | data_in;
      4'h7:    acc_nxt = acc ^ data_in;
      4'h8:    acc_nxt = ~acc;
      4'h9:    {c_nxt, acc_nxt} = {acc, 1'b0};
      4'hA:    {acc_nxt, c_nxt} = {1'b0, acc};
      4'hE:    acc_nxt = {6'b0, k};
      default: ;
    endcase
  end
  // control registers: PC, IR and state, cleared by rst_pc; reserved IR bits are not stored
  always_ff @(posedge clk or posedge rst_pc) begin
    if (rst_pc) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH) ir <= {data_in[15:12], data_in[9:0]};
    end
  end
  // data registers: ACC, carry and alu_out, cleared by rst_acc, updated only in EXECUTE
  always_ff @(posedge clk or posedge rst_acc) begin
    if (rst_acc) begin
      acc     <= '0;
      c       <= 1'b0;
      alu_out <= '0;
    end else if (state == EXECUTE) begin
      acc <= acc_nxt;
      c   <= c_nxt;
      if (alu_op) alu_out <= acc_nxt;
    end
  end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: instruction-level reference model checks of cpu with directed and random programs
module tb_cpu;
  logic        clk, rst_pc, rst_acc, wr, addr_mode;
  logic [15:0] data_in, data_out, alu_out;
  logic [9:0]  addr;
  logic [15:0] pmem [1024];
  logic [15:0] dmem [1024];
  logic [15:0] m_dmem [1024];
  logic [15:0] m_acc, m_alu;
  logic [9:0]  m_pc;
  logic        m_c, m_halt;
  int          checks, errors;

  cpu dut (.clk(clk), .rst_pc(rst_pc), .rst_acc(rst_acc), .data_in(data_in), .data_out(data_out),
           .addr(addr), .wr(wr), .addr_mode(addr_mode), .alu_out(alu_out));

  assign data_in = addr_mode ? dmem[addr] : pmem[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (wr) dmem[addr] <= data_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_d(input int a, input logic [15:0] v);
    dmem[a] = v;
    m_dmem[a] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      pmem[i] = 16'h0000;
      set_d(i, 16'h0000);
    end
  endtask

  task automatic reset_all(input bit check);
    rst_pc = 1'b1;
    rst_acc = 1'b1;
    #1;
    if (check) begin
      chk("rst_addr", addr, 0);
      chk("rst_mode", addr_mode, 0);
      chk("rst_wr", wr, 0);
      chk("rst_acc", data_out, 0);
      chk("rst_alu", alu_out, 0);
    end
    #1;
    rst_pc = 1'b0;
    rst_acc = 1'b0;
    m_pc = '0; m_acc = '0; m_alu = '0; m_c = 1'b0; m_halt = 1'b0;
  endtask

  task automatic step();
    logic [15:0] ins, m;
    logic [3:0]  o;
    logic [9:0]  kk, sa;
    logic        sta;
    int          s;
    sta = 1'b0;
    sa = '0;
    if (!m_halt) begin
      ins = pmem[m_pc];
      o = ins[15:12];
      kk = ins[9:0];
      m = m_dmem[kk];
      m_pc = m_pc + 10'd1;
      case (o)
        4'h1: m_acc = m;
        4'h2: begin m_dmem[kk] = m_acc; sta = 1'b1; sa = kk; end
        4'h3: begin s = int'(m_acc) + int'(m); m_c = s > 65535; m_acc = 16'(s); end
        4'h4: begin m_c = m_acc < m; m_acc = m_acc - m; end
        4'h5: m_acc = m_acc & m;
        4'h6: m_acc = m_acc | m;
        4'h7: m_acc = m_acc ^ m;
        4'h8: m_acc = ~m_acc;
        4'h9: begin m_c = m_acc[15]; m_acc = m_acc << 1; end
        4'hA: begin m_c = m_acc[0]; m_acc = m_acc >> 1; end
        4'hB: m_pc = kk;
        4'hC: if (m_acc == 16'h0) m_pc = kk;
        4'hD: if (m_acc[15]) m_pc = kk;
        4'hE: m_acc = {6'b0, kk};
        4'hF: m_halt = 1'b1;
        default: ;
      endcase
      if ((o >= 4'h3 && o <= 4'hA) || o == 4'hE) m_alu = m_acc;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("acc", data_out, m_acc);
    chk("alu", alu_out, m_alu);
    chk("carry", dut.c, m_c);
    chk("pc", addr, m_pc);
    chk("mode", addr_mode, 0);
    chk("wr", wr, 0);
    if (sta) chk("sta_mem", dmem[sa], m_dmem[sa]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_pc = 1'b1;
    rst_acc = 1'b1;
    clear_mem();
    @(posedge clk);
    #1;
    reset_all(1'b1);

    clear_mem();
    pmem[0] = 16'h1005; pmem[1] = 16'h3006; pmem[2] = 16'h2007; pmem[3] = 16'hF000;
    set_d(5, 16'h0003); set_d(6, 16'h0004);
    reset_all(1'b0);
    repeat (4) step();
    chk("t2_mem7", dmem[7], 16'h0007);
    chk("t2_alu", alu_out, 16'h0007);
    chk("t2_haltaddr", addr, 4);
    step();
    chk("t2_stay", addr, 4);

    clear_mem();
    pmem[0] = 16'hE3FF; pmem[1] = 16'h3005; pmem[2] = 16'hC010; pmem[16'h10] = 16'hF000;
    set_d(5, 16'hFC01);
    reset_all(1'b0);
    step(); step();
    chk("t3_acc", data_out, 16'h0000);
    chk("t3_c", dut.c, 1);
    step();
    chk("t3_jz", addr, 10'h010);

    clear_mem();
    pmem[0] = 16'hE001; pmem[1] = 16'h4005; pmem[2] = 16'hD020; pmem[16'h20] = 16'hA000; pmem[16'h21] = 16'hF000;
    set_d(5, 16'h0002);
    reset_all(1'b0);
    step(); step();
    chk("t4_acc", data_out, 16'hFFFF);
    chk("t4_c", dut.c, 1);
    step();
    chk("t4_jn", addr, 10'h020);
    step();
    chk("t4_shr", data_out, 16'h7FFF);
    chk("t4_shrc", dut.c, 1);

    clear_mem();
    pmem[0] = 16'hB3FF;
    reset_all(1'b0);
    step();
    chk("t5_jmp", addr, 10'h3FF);
    step();
    chk("t5_wrap", addr, 10'h000);

    clear_mem();
    pmem[0] = 16'hE123; pmem[1] = 16'hE045; pmem[2] = 16'h6000; pmem[3] = 16'hF000;
    set_d(0, 16'h0F00);
    reset_all(1'b0);
    step();
    rst_acc = 1'b1;
    #1;
    chk("t6_accrst", data_out, 0);
    chk("t6_alurst", alu_out, 0);
    #1;
    rst_acc = 1'b0;
    m_acc = '0; m_alu = '0; m_c = 1'b0;
    repeat (3) step();

    clear_mem();
    pmem[0] = 16'hE055; pmem[1] = 16'h2100;
    set_d(16'h100, 16'hBEEF);
    reset_all(1'b0);
    step();
    @(posedge clk);
    #1;
    chk("t6_stawr", wr, 1);
    chk("t6_staaddr", addr, 10'h100);
    rst_pc = 1'b1;
    #1;
    chk("t6_wrdrop", wr, 0);
    chk("t6_addr0", addr, 0);
    @(posedge clk);
    #1;
    rst_pc = 1'b0;
    chk("t6_nowrite", dmem[16'h100], 16'hBEEF);
    m_pc = '0;
    m_halt = 1'b0;
    step();

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 1024; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'hE;
        pmem[i] = w;
        set_d(i, 16'($urandom));
      end
      reset_all(1'b0);
      repeat (80) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
